// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register address map shared by the GPIO bank files
package gpio_pkg;

  localparam int GPIO_AW = 3;

  localparam logic [GPIO_AW-1:0] GPIO_ADDR_OUT     = 3'd0;
  localparam logic [GPIO_AW-1:0] GPIO_ADDR_OE      = 3'd1;
  localparam logic [GPIO_AW-1:0] GPIO_ADDR_IN      = 3'd2;
  localparam logic [GPIO_AW-1:0] GPIO_ADDR_STATUS  = 3'd3;
  localparam logic [GPIO_AW-1:0] GPIO_ADDR_RISE_EN = 3'd4;
  localparam logic [GPIO_AW-1:0] GPIO_ADDR_FALL_EN = 3'd5;

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - single-pin two-flop synchroniser with debounce under GPIO_BANK_DEBOUNCE_EN
module gpio_debounce #(
  parameter int DB_CYCLES = 1000
) (
  input  logic i_sysclk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_in_q
);

  logic sync_1;
  logic sync_2;

  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= i_pin;
      sync_2 <= sync_1;
    end
  end

`ifdef GPIO_BANK_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [CW-1:0] cnt;
  logic          in_q;

  // Any return to the filtered value restarts the stability count.
  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      cnt  <= '0;
      in_q <= 1'b0;
    end else if (sync_2 == in_q) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      in_q <= sync_2;
      cnt  <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_in_q = in_q;
`else
  assign o_in_q = sync_2;
`endif

endmodule

// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - GPIO bank with register port, edge status and irq; debounce under GPIO_BANK_DEBOUNCE_EN
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int WIDTH     = 15,
  parameter int DB_CYCLES = 1000
) (
  input  logic               i_sysclk,
  input  logic               i_rst,
  input  logic [WIDTH-1:0]   i_gpio_in,
  output logic [WIDTH-1:0]   o_gpio_out,
  output logic [WIDTH-1:0]   o_gpio_oe,
  input  logic               i_wr_en,
  input  logic               i_rd_en,
  input  logic [GPIO_AW-1:0] i_addr,
  input  logic [WIDTH-1:0]   i_wdata,
  output logic [WIDTH-1:0]   o_rdata,
  output logic               o_rvalid,
  output logic               o_irq
);

  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] oe_r;
  logic [WIDTH-1:0] status_r;
  logic [WIDTH-1:0] rise_en_r;
  logic [WIDTH-1:0] fall_en_r;
  logic [WIDTH-1:0] in_q;
  logic [WIDTH-1:0] in_q_d;
  logic [WIDTH-1:0] set_mask;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] rd_mux;
  logic [WIDTH-1:0] rdata_r;
  logic             rvalid_r;
  logic             irq_r;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .i_sysclk(i_sysclk),
      .i_rst   (i_rst),
      .i_pin   (i_gpio_in[i]),
      .o_in_q  (in_q[i])
    );
  end

  assign set_mask = ((in_q & ~in_q_d) & rise_en_r) | ((~in_q & in_q_d) & fall_en_r);
  assign clr_mask = (i_wr_en && (i_addr == GPIO_ADDR_STATUS)) ? i_wdata : '0;

  always_comb begin
    rd_mux = '0;
    case (i_addr)
      GPIO_ADDR_OUT:     rd_mux = out_r;
      GPIO_ADDR_OE:      rd_mux = oe_r;
      GPIO_ADDR_IN:      rd_mux = in_q;
      GPIO_ADDR_STATUS:  rd_mux = status_r;
      GPIO_ADDR_RISE_EN: rd_mux = rise_en_r;
      GPIO_ADDR_FALL_EN: rd_mux = fall_en_r;
      default:           rd_mux = '0;
    endcase
  end

  // Set is ORed in after the clear so a coincident edge keeps its flag.
  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      out_r     <= '0;
      oe_r      <= '0;
      status_r  <= '0;
      rise_en_r <= '0;
      fall_en_r <= '0;
      in_q_d    <= '0;
      rdata_r   <= '0;
      rvalid_r  <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      if (i_wr_en) begin
        case (i_addr)
          GPIO_ADDR_OUT:     out_r     <= i_wdata;
          GPIO_ADDR_OE:      oe_r      <= i_wdata;
          GPIO_ADDR_RISE_EN: rise_en_r <= i_wdata;
          GPIO_ADDR_FALL_EN: fall_en_r <= i_wdata;
          default:           ;
        endcase
      end
      status_r <= (status_r & ~clr_mask) | set_mask;
      irq_r    <= |status_r;
      in_q_d   <= in_q;
      rvalid_r <= i_rd_en;
      if (i_rd_en) rdata_r <= rd_mux;
    end
  end

  assign o_gpio_out = out_r;
  assign o_gpio_oe  = oe_r;
  assign o_rdata    = rdata_r;
  assign o_rvalid   = rvalid_r;
  assign o_irq      = irq_r;

endmodule

// File: tb/tb_gpio_bank.sv
// tb/tb_gpio_bank.sv - directed self-checking bench for gpio_bank (WIDTH=15, DB_CYCLES=8)
module tb_gpio_bank;

  localparam int W  = 15;
  localparam int DB = 8;
`ifdef GPIO_BANK_DEBOUNCE_EN
  localparam int LAT = 2 + DB;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] gpio_in;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_oe;
  logic         wr_en;
  logic         rd_en;
  logic [2:0]   addr;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;
  logic         rvalid;
  logic         irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gpio_bank #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .i_sysclk  (clk),
    .i_rst     (rst),
    .i_gpio_in (gpio_in),
    .o_gpio_out(gpio_out),
    .o_gpio_oe (gpio_oe),
    .i_wr_en   (wr_en),
    .i_rd_en   (rd_en),
    .i_addr    (addr),
    .i_wdata   (wdata),
    .o_rdata   (rdata),
    .o_rvalid  (rvalid),
    .o_irq     (irq)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [W-1:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [W-1:0] d,
                         output logic v1, output logic v2);
    rd_en = 1'b1;
    addr  = a;
    tick();
    d     = rdata;
    v1    = rvalid;
    rd_en = 1'b0;
    tick();
    v2    = rvalid;
  endtask

  task automatic test_reset;
    logic [W-1:0] d;
    logic v1, v2;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    n_checks++;
    if ({gpio_out, gpio_oe, rdata, rvalid, irq} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: out=%h oe=%h rdata=%h rvalid=%b irq=%b, expected all 0",
               gpio_out, gpio_oe, rdata, rvalid, irq);
    end
    for (int a = 0; a < 6; a++) begin
      do_read(3'(a), d, v1, v2);
      n_checks++;
      if (d !== '0 || v1 !== 1'b1 || v2 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: rdata=%h rvalid=%b,%b expected 0 and 1,0", a, d, v1, v2);
      end
    end
  endtask

  task automatic test_out_oe;
    logic [W-1:0] d;
    logic v1, v2;
    do_write(3'd0, 15'h5A5A);
    n_checks++;
    if (gpio_out !== 15'h5A5A || gpio_oe !== 15'h0000) begin
      n_fail++;
      $display("FAIL out_write: out=%h oe=%h expected 5a5a 0000", gpio_out, gpio_oe);
    end
    do_write(3'd1, 15'h7FFF);
    n_checks++;
    if (gpio_oe !== 15'h7FFF) begin
      n_fail++;
      $display("FAIL oe_write: oe=%h expected 7fff", gpio_oe);
    end
    do_read(3'd0, d, v1, v2);
    n_checks++;
    if (d !== 15'h5A5A || v1 !== 1'b1) begin
      n_fail++;
      $display("FAIL out_readback: rdata=%h rvalid=%b expected 5a5a 1", d, v1);
    end
    do_read(3'd1, d, v1, v2);
    n_checks++;
    if (d !== 15'h7FFF) begin
      n_fail++;
      $display("FAIL oe_readback: rdata=%h expected 7fff", d);
    end
    // Unmapped addresses ignore writes and read back 0.
    do_write(3'd6, 15'h1234);
    do_read(3'd6, d, v1, v2);
    n_checks++;
    if (d !== '0 || gpio_out !== 15'h5A5A) begin
      n_fail++;
      $display("FAIL unmapped: rdata=%h out=%h expected 0000 5a5a", d, gpio_out);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] d;
    logic v1, v2;
    rd_en = 1'b1;
    addr  = 3'd0;
    tick();
    n_checks++;
    if (rdata !== 15'h5A5A || rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: rdata=%h rvalid=%b expected 5a5a 1", rdata, rvalid);
    end
    addr = 3'd1;
    tick();
    n_checks++;
    if (rdata !== 15'h7FFF || rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: rdata=%h rvalid=%b expected 7fff 1", rdata, rvalid);
    end
    rd_en = 1'b0;
    tick();
    n_checks++;
    if (rdata !== 15'h7FFF || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_hold: rdata=%h rvalid=%b expected 7fff 0", rdata, rvalid);
    end
    // Read and write of the same register in one cycle returns the old value.
    rd_en = 1'b1;
    wr_en = 1'b1;
    addr  = 3'd0;
    wdata = 15'h1234;
    tick();
    rd_en = 1'b0;
    wr_en = 1'b0;
    n_checks++;
    if (rdata !== 15'h5A5A || gpio_out !== 15'h1234) begin
      n_fail++;
      $display("FAIL rd_wr_same: rdata=%h out=%h expected 5a5a 1234", rdata, gpio_out);
    end
    do_read(3'd0, d, v1, v2);
    n_checks++;
    if (d !== 15'h1234) begin
      n_fail++;
      $display("FAIL rd_after_wr: rdata=%h expected 1234", d);
    end
  endtask

  task automatic test_glitch;
    logic [W-1:0] d;
    logic v1, v2;
    do_write(3'd4, 15'h0008);
`ifdef GPIO_BANK_DEBOUNCE_EN
    gpio_in[3] = 1'b1;
    tick(5);
    gpio_in[3] = 1'b0;
    tick(15);
    do_read(3'd2, d, v1, v2);
    n_checks++;
    if (d !== '0) begin
      n_fail++;
      $display("FAIL glitch_in: IN=%h expected 0000", d);
    end
    do_read(3'd3, d, v1, v2);
    n_checks++;
    if (d !== '0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_status: STATUS=%h irq=%b expected 0000 0", d, irq);
    end
`endif
  endtask

  task automatic test_rise_irq;
    logic [W-1:0] d;
    logic v1, v2;
    gpio_in[3] = 1'b1;
    tick(LAT - 1);
    n_checks++;
    if (dut.in_q[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL rise_early: in_q[3]=%b expected 0 at cycle %0d", dut.in_q[3], LAT - 1);
    end
    tick();
    n_checks++;
    if (dut.in_q[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_latency: in_q[3]=%b expected 1 at cycle %0d", dut.in_q[3], LAT);
    end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_early: irq=%b expected 0", irq);
    end
    tick();
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_set: irq=%b expected 1", irq);
    end
    do_read(3'd3, d, v1, v2);
    n_checks++;
    if (d !== 15'h0008) begin
      n_fail++;
      $display("FAIL status_rise: STATUS=%h expected 0008", d);
    end
    do_read(3'd2, d, v1, v2);
    n_checks++;
    if (d !== 15'h0008) begin
      n_fail++;
      $display("FAIL in_rise: IN=%h expected 0008", d);
    end
    do_write(3'd3, 15'h0000);
    do_read(3'd3, d, v1, v2);
    n_checks++;
    if (d !== 15'h0008) begin
      n_fail++;
      $display("FAIL w0_noeffect: STATUS=%h expected 0008", d);
    end
    do_write(3'd3, 15'h0008);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_lag: irq=%b expected 1 one cycle after clear", irq);
    end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear: irq=%b expected 0", irq);
    end
    do_read(3'd3, d, v1, v2);
    n_checks++;
    if (d !== '0) begin
      n_fail++;
      $display("FAIL status_clear: STATUS=%h expected 0000", d);
    end
  endtask

  task automatic test_set_wins;
    logic [W-1:0] d;
    logic v1, v2;
    do_write(3'd4, 15'h0009);
    gpio_in[0] = 1'b1;
    tick(LAT);
    do_write(3'd3, 15'h0001);
    do_read(3'd3, d, v1, v2);
    n_checks++;
    if (d !== 15'h0001) begin
      n_fail++;
      $display("FAIL set_wins: STATUS=%h expected 0001", d);
    end
    do_write(3'd3, 15'h0001);
    do_read(3'd3, d, v1, v2);
    n_checks++;
    if (d !== '0) begin
      n_fail++;
      $display("FAIL set_wins_clear: STATUS=%h expected 0000", d);
    end
  endtask

  task automatic test_fall;
    logic [W-1:0] d;
    logic v1, v2;
    do_write(3'd5, 15'h0001);
    tick(2);
    gpio_in[0] = 1'b0;
    tick(LAT - 1);
    n_checks++;
    if (dut.in_q[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL fall_early: in_q[0]=%b expected 1", dut.in_q[0]);
    end
    tick();
    n_checks++;
    if (dut.in_q[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_latency: in_q[0]=%b expected 0 at cycle %0d", dut.in_q[0], LAT);
    end
    tick(2);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL fall_irq: irq=%b expected 1", irq);
    end
    do_read(3'd3, d, v1, v2);
    n_checks++;
    if (d !== 15'h0001) begin
      n_fail++;
      $display("FAIL fall_status: STATUS=%h expected 0001", d);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] d;
    logic v1, v2;
    rst   = 1'b1;
    rd_en = 1'b1;
    wr_en = 1'b1;
    addr  = 3'd0;
    wdata = 15'h7777;
    tick();
    rst   = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    n_checks++;
    if ({gpio_out, gpio_oe, rdata, rvalid, irq} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: out=%h oe=%h rdata=%h rvalid=%b irq=%b expected all 0",
               gpio_out, gpio_oe, rdata, rvalid, irq);
    end
    do_read(3'd3, d, v1, v2);
    n_checks++;
    if (d !== '0 || v1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_status: STATUS=%h rvalid=%b expected 0000 1", d, v1);
    end
  endtask

  initial begin
    rst     = 1'b1;
    gpio_in = '0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    addr    = '0;
    wdata   = '0;
    tick();
    test_reset();
    test_out_oe();
    test_back_to_back();
    test_glitch();
    test_rise_irq();
    test_set_wins();
    test_fall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised GPIO bank for the Xyloni board top level: one instance per header (J1, J2, J3, or on-board LEDs/buttons), driving the split OUT/OE pad pairs and sampling the IN pad. It adds a two-flop input synchroniser, an optional per-pin debounce, and per-pin rising/falling edge detection with sticky interrupt status. A small single-cycle register port gives firmware or RTL control logic access to all of it.

## Interface
Parameters:
- WIDTH, 15, number of pins in the bank (1..32)
- DB_CYCLES, 1000, consecutive stable cycles required before a debounced input changes (>=1)

Ports:
- i_sysclk  in  1  system clock, single clock domain
- i_rst  in  1  reset, synchronous, active-high
- i_gpio_in  in  WIDTH  raw pad inputs, asynchronous
- o_gpio_out  out  WIDTH  pad output values
- o_gpio_oe  out  WIDTH  pad output enables (1 = drive)
- i_wr_en  in  1  register write strobe
- i_rd_en  in  1  register read strobe
- i_addr  in  3  register address
- i_wdata  in  WIDTH  write data
- o_rdata  out  WIDTH  read data
- o_rvalid  out  1  read data valid pulse
- o_irq  out  1  level interrupt, OR of the status register

## Operation
- Register map, by i_addr:
  - 0 OUT: read/write, drives o_gpio_out.
  - 1 OE: read/write, drives o_gpio_oe.
  - 2 IN: read-only, filtered input value.
  - 3 STATUS: sticky edge flags, write-1-to-clear.
  - 4 RISE_EN: read/write.
  - 5 FALL_EN: read/write.
  - 6–7: reads return 0; writes are ignored.
- Input path per pin:
  - Two-flop synchroniser, then debounce, then the filtered value `in_q`.
  - Debounce: a per-pin counter resets whenever the synced value equals `in_q`. Otherwise it increments; when the count reaches DB_CYCLES−1, `in_q` takes the synced value and the counter returns to 0.
  - Counter width is $clog2(DB_CYCLES+1). The counter saturates and never wraps.
- Edge detection on `in_q`:
  - rise = `in_q` & ~`in_q_d`; fall = ~`in_q` & `in_q_d`.
  - STATUS[i] is set when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- Simultaneous set and w1c clear of the same STATUS bit: set wins, and the bit stays 1.
- Writing 0 to a STATUS bit has no effect.
- Read and write of the same address in the same cycle: the read returns the pre-write value.
- Reset values:
  - All registers 0. o_gpio_out=0 and o_gpio_oe=0, so all pins are inputs after reset.
  - Synchroniser, `in_q`, `in_q_d` and counters are 0.
  - o_rdata=0, o_rvalid=0, o_irq=0.
- Reset mid-operation: all state returns to reset values on the next edge. There are no partial writes. A read issued in the same cycle as i_rst produces no o_rvalid.

## Timing
- Register write: the new value appears on o_gpio_out / o_gpio_oe on the cycle after the i_wr_en edge (1-cycle latency).
- Read: o_rdata is valid and o_rvalid=1 for exactly one cycle, the cycle after i_rd_en. o_rdata holds its value until the next read.
- Back-to-back reads on consecutive cycles are supported at one per cycle.
- Pad-to-`in_q` latency:
  - Without debounce: 2 cycles.
  - With debounce: 2 + DB_CYCLES cycles for a clean step.
  - A glitch shorter than DB_CYCLES synced cycles never reaches `in_q`.
- Edge-to-STATUS: STATUS sets 1 cycle after `in_q` changes. o_irq follows 1 cycle later (registered).
- STATUS clear: the bit reads 0 on the cycle after the write. o_irq deasserts the cycle after that, provided no other bit is set.

## Configuration
- GPIO_BANK_DEBOUNCE_EN defined:
  - The debounce counters are instantiated and DB_CYCLES applies.
- Not defined:
  - `in_q` is the second synchroniser flop directly.
  - No counters are built and DB_CYCLES is ignored.
  - All other behaviour is unchanged.

## Structure
- Shared package gpio_pkg holds:
  - Address constants GPIO_ADDR_OUT..GPIO_ADDR_FALL_EN (0..5).
  - Address width constant GPIO_AW=3.
- One sub-module, gpio_debounce:
  - Single pin: synchroniser plus counter, parameter DB_CYCLES.
  - Instantiated WIDTH times in a generate loop.
  - Its counter logic sits under GPIO_BANK_DEBOUNCE_EN.

## Test plan
- Reset, then read all six registers → every o_rdata = 0, o_rvalid exactly one cycle per read, and o_gpio_oe = 0.
- Write OUT=0x5A5A, OE=0x7FFF (WIDTH=15) → o_gpio_out=0x5A5A and o_gpio_oe=0x7FFF one cycle after the respective writes; readback matches.
- DB_CYCLES=8, macro defined:
  - Pin 3 high for 5 cycles then low → IN stays 0 and no STATUS.
  - Pin 3 held high → IN[3]=1 at cycle 2+8 after the step.
- RISE_EN=0x0008, pin 3 steps high → STATUS=0x0008, o_irq=1; write STATUS=0x0008 → STATUS=0, o_irq=0 after two cycles.
- w1c of STATUS[0] in the same cycle as a new rising edge on pin 0 with RISE_EN[0]=1 → STATUS[0] stays 1.
- Macro undefined, FALL_EN=0x0001, pin 0 falls → IN[0]=0 at 2 cycles, STATUS[0]=1 at 3 cycles; assert i_rst mid-sequence → all outputs 0 next cycle.
